keypad_scanner: RTL and testbench

- Drives a 4x4 membrane keypad matrix and debounces the readings.
- Produces the `key[4:0]` code and the `keypad_pressed` level consumed by the game state machine: power/start, menu advance, hero confirm, yes/no.
- Sits between the board keypad pins and all keypad consumers.
- One instance per design, running on the 27 MHz system clock.

---
 rtl/keypad_pkg.sv | 25 ++
 rtl/keypad_debounce.sv | 90 +++++++++
 rtl/keypad_scanner.sv | 105 ++++++++++
 tb/tb_keypad_scanner.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key codes, position-to-code map, debounce states.
package keypad_pkg;

    localparam logic [4:0] KEY_NONE = 5'h1F;
    localparam logic [4:0] KEY_A    = 5'd10;
    localparam logic [4:0] KEY_B    = 5'd11;
    localparam logic [4:0] KEY_C    = 5'd12;
    localparam logic [4:0] KEY_D    = 5'd13;
    localparam logic [4:0] KEY_STAR = 5'd14;
    localparam logic [4:0] KEY_HASH = 5'd15;

    // Indexed by position p = row*4 + col, row 0 at the top.
    localparam logic [4:0] KEYMAP [16] = '{
        5'd1,     5'd2, 5'd3,     KEY_A,
        5'd4,     5'd5, 5'd6,     KEY_B,
        5'd7,     5'd8, 5'd9,     KEY_C,
        KEY_STAR, 5'd0, KEY_HASH, KEY_D
    };

    typedef enum logic {
        IDLE,
        PRESSED
    } deb_state_e;

endpackage

// File: rtl/keypad_debounce.sv
// Frame-rate debouncer: compares successive frame codes and accepts a code once
// it has been stable for DEBOUNCE_FRAMES frame ends.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_FRAMES = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] code_i,
    input  logic       frame_end_i,
    output logic [4:0] key_o,
    output logic       pressed_o,
    output logic       event_o
);

    deb_state_e state_q, state_d;
    logic [4:0] prev_q, prev_d;
    logic [3:0] cnt_q, cnt_d;
    logic [4:0] key_q, key_d;
    logic       pressed_q, pressed_d;
    logic       event_q, event_d;
    logic       stable;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            prev_q    <= KEY_NONE;
            cnt_q     <= '0;
            key_q     <= KEY_NONE;
            pressed_q <= 1'b0;
            event_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            key_q     <= key_d;
            pressed_q <= pressed_d;
            event_q   <= event_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        cnt_d     = cnt_q;
        key_d     = key_q;
        pressed_d = pressed_q;
        event_d   = 1'b0;
        stable    = 1'b0;
        if (frame_end_i) begin
            if (code_i == prev_q) begin
                cnt_d = (cnt_q >= 4'(DEBOUNCE_FRAMES)) ? cnt_q : cnt_q + 4'd1;
            end else begin
                cnt_d  = 4'd1;
                prev_d = code_i;
            end
            // The FSM acts on the count including this frame.
            stable = (cnt_d == 4'(DEBOUNCE_FRAMES));
            case (state_q)
                IDLE: begin
                    if (stable && code_i != KEY_NONE) begin
                        state_d   = PRESSED;
                        key_d     = code_i;
                        pressed_d = 1'b1;
                        event_d   = 1'b1;
                    end
                end
                PRESSED: begin
                    if (stable) begin
                        if (code_i == KEY_NONE) begin
                            state_d   = IDLE;
                            key_d     = KEY_NONE;
                            pressed_d = 1'b0;
                        end else if (code_i != key_q) begin
                            key_d   = code_i;
                            event_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign key_o     = key_q;
    assign pressed_o = pressed_q;
    assign event_o   = event_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with synchronized row sampling and frame debouncing.
// Optional KEYPAD_MULTI_REJECT_EN: frames with two or more keys read as "none".
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 27000,
    parameter int unsigned SETTLE          = 8,
    parameter int unsigned DEBOUNCE_FRAMES = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [4:0] key,
    output logic       keypad_pressed,
    output logic       key_event
);

    localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    col_q, col_d;
    logic [3:0]    row_s1_q, row_s2_q;
    logic [15:0]   hits_q, hits_d;
    logic          last_dwell;
    logic          sample_now;
    logic          frame_end;
    logic [4:0]    frame_code;
    logic          found;
`ifdef KEYPAD_MULTI_REJECT_EN
    logic [4:0]    n_hits;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell_q  <= '0;
            col_q    <= '0;
            row_s1_q <= '1;
            row_s2_q <= '1;
            hits_q   <= '0;
        end else begin
            dwell_q  <= dwell_d;
            col_q    <= col_d;
            row_s1_q <= row_n;
            row_s2_q <= row_s1_q;
            hits_q   <= hits_d;
        end
    end

    always_comb begin
        last_dwell = (dwell_q == DW'(SCAN_DIV - 1));
        sample_now = (dwell_q == DW'(SETTLE + 2));
        frame_end  = last_dwell && (col_q == 2'd3);
        dwell_d    = last_dwell ? '0 : dwell_q + 1'b1;
        col_d      = last_dwell ? col_q + 2'd1 : col_q;
        hits_d     = hits_q;
        // Each column overwrites its own four positions, so no per-frame clear.
        if (sample_now) begin
            for (int unsigned r = 0; r < 4; r++) begin
                hits_d[r*4 + col_q] = ~row_s2_q[r];
            end
        end
    end

    always_comb begin
        frame_code = KEY_NONE;
        found      = 1'b0;
`ifdef KEYPAD_MULTI_REJECT_EN
        n_hits     = '0;
`endif
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                if (hits_q[r*4 + c]) begin
`ifdef KEYPAD_MULTI_REJECT_EN
                    n_hits = n_hits + 5'd1;
`endif
                    if (!found) begin
                        found      = 1'b1;
                        frame_code = KEYMAP[r*4 + c];
                    end
                end
            end
        end
`ifdef KEYPAD_MULTI_REJECT_EN
        if (n_hits > 5'd1) begin
            frame_code = KEY_NONE;
        end
`endif
    end

    assign col_n = ~(4'b0001 << col_q);

    keypad_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .code_i     (frame_code),
        .frame_end_i(frame_end),
        .key_o      (key),
        .pressed_o  (keypad_pressed),
        .event_o    (key_event)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: SCAN_DIV=16, SETTLE=2, DEBOUNCE_FRAMES=3 (64-cycle frames).
module tb_keypad_scanner;

    logic       clk;
    logic       rst;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [4:0] key;
    logic       keypad_pressed;
    logic       key_event;

    logic [15:0] keys;
    int unsigned cyc;
    int unsigned n_checks;
    int unsigned n_fail;

    typedef struct {
        logic [4:0]  code;
        int unsigned at;
    } exp_t;
    exp_t sb_q[$];

    localparam int unsigned P_1    = 0;
    localparam int unsigned P_A    = 3;
    localparam int unsigned P_B    = 7;
    localparam int unsigned P_9    = 10;
    localparam int unsigned P_HASH = 14;
    localparam int unsigned P_D    = 15;

    keypad_scanner #(
        .SCAN_DIV       (16),
        .SETTLE         (2),
        .DEBOUNCE_FRAMES(3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .row_n         (row_n),
        .col_n         (col_n),
        .key           (key),
        .keypad_pressed(keypad_pressed),
        .key_event     (key_event)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Membrane model: a closed switch pulls its row low while its column is driven.
    always_comb begin
        row_n = '1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4 + c] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic at_cycle(input int unsigned n);
        int unsigned guard;
        guard = 0;
        while (cyc != n) begin
            @(negedge clk);
            guard++;
            if (guard > 5000) begin
                $display("FAIL at_cycle_timeout: got %0d expected %0d", cyc, n);
                $fatal(1, "timeout");
            end
        end
    endtask

    task automatic expect_event(input logic [4:0] code, input int unsigned at);
        exp_t e;
        e.code = code;
        e.at   = at;
        sb_q.push_back(e);
    endtask

    // Monitor: every key_event pulse must match the next scoreboard entry.
    always @(negedge clk) begin
        if (!rst && key_event) begin
            if (sb_q.size() == 0) begin
                check("unexpected_event", {27'd0, key}, 32'h1F);
                check("unexpected_event_flag", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("event_key", {27'd0, key}, {27'd0, e.code});
                check("event_pressed", {31'd0, keypad_pressed}, 1);
                check("event_cycle", cyc, e.at);
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        keys     = '0;
        rst      = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_col_n", {28'd0, col_n}, 4'b1110);
        check("rst_key", {27'd0, key}, 5'h1F);
        check("rst_pressed", {31'd0, keypad_pressed}, 0);
        check("rst_event", {31'd0, key_event}, 0);
        rst = 1'b0;

        at_cycle(8);   check("col0", {28'd0, col_n}, 4'b1110);
        at_cycle(24);  check("col1", {28'd0, col_n}, 4'b1101);
        at_cycle(40);  check("col2", {28'd0, col_n}, 4'b1011);
        at_cycle(56);  check("col3", {28'd0, col_n}, 4'b0111);
        at_cycle(72);  check("col0_wrap", {28'd0, col_n}, 4'b1110);
        at_cycle(128); check("idle_key", {27'd0, key}, 5'h1F);
        check("idle_pressed", {31'd0, keypad_pressed}, 0);

        // Key A held for frames 2..5, released from frame 6.
        keys[P_A] = 1'b1;
        expect_event(5'd10, 320);
        at_cycle(319); check("A_not_early", {27'd0, key}, 5'h1F);
        at_cycle(384); check("A_key", {27'd0, key}, 5'd10);
        check("A_pressed", {31'd0, keypad_pressed}, 1);
        keys = '0;
        at_cycle(575); check("A_held", {31'd0, keypad_pressed}, 1);
        at_cycle(576); check("A_rel_key", {27'd0, key}, 5'h1F);
        check("A_rel_pressed", {31'd0, keypad_pressed}, 0);

        // B bounces frames 10..15, then stable from frame 16.
        for (int i = 0; i < 6; i++) begin
            at_cycle(640 + 64*i);
            keys = '0;
            keys[P_B] = (i % 2 == 0);
        end
        at_cycle(1024);
        keys = '0;
        keys[P_B] = 1'b1;
        check("B_no_early", {31'd0, keypad_pressed}, 0);
        expect_event(5'd11, 1216);
        at_cycle(1215); check("B_not_early", {27'd0, key}, 5'h1F);
        at_cycle(1280); check("B_key", {27'd0, key}, 5'd11);
        keys = '0;
        at_cycle(1472); check("B_rel_key", {27'd0, key}, 5'h1F);

        // # then directly D.
        at_cycle(1536);
        keys[P_HASH] = 1'b1;
        expect_event(5'd15, 1728);
        at_cycle(1792); check("hash_key", {27'd0, key}, 5'd15);
        keys = '0;
        keys[P_D] = 1'b1;
        expect_event(5'd13, 1984);
        at_cycle(1900); check("hash_to_D_held", {31'd0, keypad_pressed}, 1);
        check("hash_to_D_key", {27'd0, key}, 5'd15);
        at_cycle(1990); check("D_key", {27'd0, key}, 5'd13);
        check("D_pressed", {31'd0, keypad_pressed}, 1);
        at_cycle(2048);
        keys = '0;
        at_cycle(2240); check("D_rel_key", {27'd0, key}, 5'h1F);

        // Chord 1 + 9.
        at_cycle(2304);
        keys[P_1] = 1'b1;
        keys[P_9] = 1'b1;
`ifdef KEYPAD_MULTI_REJECT_EN
        at_cycle(2496); check("chord_key", {27'd0, key}, 5'h1F);
        check("chord_pressed", {31'd0, keypad_pressed}, 0);
`else
        expect_event(5'd1, 2496);
        at_cycle(2496); check("chord_key", {27'd0, key}, 5'd1);
        check("chord_pressed", {31'd0, keypad_pressed}, 1);
`endif
        at_cycle(2560);
        keys = '0;
        at_cycle(2752); check("chord_rel_key", {27'd0, key}, 5'h1F);

        // Reset while A is held; the key is re-accepted three frames later.
        at_cycle(2816);
        keys[P_A] = 1'b1;
        expect_event(5'd10, 3008);
        at_cycle(3040); check("pre_rst_pressed", {31'd0, keypad_pressed}, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_key", {27'd0, key}, 5'h1F);
        check("mid_rst_pressed", {31'd0, keypad_pressed}, 0);
        check("mid_rst_event", {31'd0, key_event}, 0);
        check("mid_rst_col_n", {28'd0, col_n}, 4'b1110);
        @(negedge clk);
        rst = 1'b0;
        expect_event(5'd10, 192);
        at_cycle(191); check("rearm_not_early", {31'd0, keypad_pressed}, 0);
        at_cycle(256); check("rearm_key", {27'd0, key}, 5'd10);
        check("rearm_pressed", {31'd0, keypad_pressed}, 1);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
